wave_rom_arbiter: RTL and testbench

//  Shares one synchronous waveform ROM (64x10, 50 valid entries) between two read

---
 rtl/wave_rom_arbiter.sv | 116 +++++++++++
 tb/tb_wave_rom_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_rom_arbiter.sv
// wave_rom_arbiter: shares one synchronous waveform ROM between two read requesters.
// Per-cycle arbitration, registered ROM address with wrap above DEPTH, and a tag
// pipeline that routes ROM data back to the winning requester.
// Optional build macro FIXED_PRIO_EN: requester 1 always wins under contention.
module wave_rom_arbiter #(
  parameter int AW      = 6,
  parameter int DW      = 10,
  parameter int DEPTH   = 50,
  parameter int ROM_LAT = 1
) (
  input  logic          clk_100m,
  input  logic          rst_n,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic [DW-1:0] rd_data1,
  output logic          rd_valid1,
  input  logic          req2,
  input  logic [AW-1:0] addr2,
  output logic          gnt2,
  output logic [DW-1:0] rd_data2,
  output logic          rd_valid2,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  // One stage per clock between the address register and douta, plus the capture stage.
  localparam int TL = ROM_LAT + 1;
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  logic [TL-1:0] tag_valid;
  logic [TL-1:0] tag_id;      // 1 = requester 2
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] wrap_addr;

`ifndef FIXED_PRIO_EN
  logic rr_ptr;               // 0 = requester 1 preferred on contention
`endif

  // Grant decision: a lone request always wins, contention resolved by priority scheme.
  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (req1 && req2) begin
`ifdef FIXED_PRIO_EN
      gnt1 = 1'b1;
`else
      gnt1 = ~rr_ptr;
      gnt2 = rr_ptr;
`endif
    end else begin
      gnt1 = req1;
      gnt2 = req2;
    end
  end

  // Address mux and wrap; input range tops out at 63, so one subtraction is enough.
  always_comb begin
    sel_addr  = gnt2 ? addr2 : addr1;
    wrap_addr = (sel_addr >= DEPTH_W) ? (sel_addr - DEPTH_W) : sel_addr;
  end

`ifndef FIXED_PRIO_EN
  // Round-robin pointer flips to the other side after every grant, idle cycles keep it.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (gnt1) begin
      rr_ptr <= 1'b1;
    end else if (gnt2) begin
      rr_ptr <= 1'b0;
    end
  end
`endif

  // ROM address register and return-tag pipeline.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      if (gnt1 || gnt2) begin
        rom_addr <= wrap_addr;
      end
      tag_valid <= {tag_valid[TL-2:0], gnt1 | gnt2};
      tag_id    <= {tag_id[TL-2:0], gnt2};
    end
  end

  // Capture douta into the owning requester's data register when its tag matures.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1  <= '0;
      rd_data2  <= '0;
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
    end else begin
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
      if (tag_valid[TL-1]) begin
        if (tag_id[TL-1]) begin
          rd_data2  <= rom_data;
          rd_valid2 <= 1'b1;
        end else begin
          rd_data1  <= rom_data;
          rd_valid1 <= 1'b1;
        end
      end
    end
  end

  assign busy = |tag_valid;

endmodule

// File: tb/tb_wave_rom_arbiter.sv
// Testbench for wave_rom_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-indexed reference model. Honours FIXED_PRIO_EN when defined.
module tb_wave_rom_arbiter;

  localparam int AW      = 6;
  localparam int DW      = 10;
  localparam int DEPTH   = 50;
  localparam int ROM_LAT = 1;
  localparam int RET     = ROM_LAT + 2;   // grant -> rd_valid distance in cycles

  logic          clk_100m = 1'b0;
  logic          rst_n = 1'b0;
  logic          req1 = 1'b0, req2 = 1'b0;
  logic [AW-1:0] addr1 = '0, addr2 = '0;
  logic          gnt1, gnt2, rd_valid1, rd_valid2, busy;
  logic [DW-1:0] rd_data1, rd_data2, rom_data;
  logic [AW-1:0] rom_addr;

  int n_cmp = 0;
  int n_err = 0;

  wave_rom_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .ROM_LAT(ROM_LAT)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rd_data1(rd_data1), .rd_valid1(rd_valid1),
    .req2(req2), .addr2(addr2), .gnt2(gnt2), .rd_data2(rd_data2), .rd_valid2(rd_valid2),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk_100m = ~clk_100m;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return DW'(int'(a) * 41 + 7);
  endfunction

  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] a);
    return (int'(a) >= DEPTH) ? AW'(int'(a) - DEPTH) : a;
  endfunction

  // Synchronous ROM model with ROM_LAT clocks from address to douta.
  logic [DW-1:0] rom_pipe [0:ROM_LAT-1];
  always @(posedge clk_100m) begin
    rom_pipe[0] <= rom_fn(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  // Drive one cycle's inputs at the falling edge, then settle.
  task automatic set_in(input logic r1, input logic [AW-1:0] a1,
                        input logic r2, input logic [AW-1:0] a2);
    @(negedge clk_100m);
    req1 = r1; addr1 = a1; req2 = r2; addr2 = a2;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_100m);
    req1 = 1'b0; req2 = 1'b0; addr1 = '0; addr2 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_100m);
    rst_n = 1'b0; req1 = 1'b0; req2 = 1'b0;
    #1;
    n_cmp++;
    if ({gnt1, gnt2, rd_valid1, rd_valid2, busy} !== 5'b0 || rom_addr !== '0 ||
        rd_data1 !== '0 || rd_data2 !== '0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b%b vld=%b%b busy=%b rom_addr=%0d d1=%0d d2=%0d, required all zero",
               gnt1, gnt2, rd_valid1, rd_valid2, busy, rom_addr, rd_data1, rd_data2);
    end
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    set_in(1'b1, 6'd5, 1'b0, 6'd0);
    n_cmp++;
    if (gnt1 !== 1'b1 || gnt2 !== 1'b0) begin
      n_err++; $display("FAIL single_gnt: gnt1=%b gnt2=%b, required 1 0", gnt1, gnt2);
    end
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b0, 6'd0, 1'b0, 6'd0);
      if (k == 1) begin
        n_cmp++;
        if (rom_addr !== 6'd5 || busy !== 1'b1) begin
          n_err++; $display("FAIL single_addr: rom_addr=%0d busy=%b, required 5 1", rom_addr, busy);
        end
      end
      n_cmp++;
      if (rd_valid1 !== (k == RET) || rd_valid2 !== 1'b0) begin
        n_err++; $display("FAIL single_valid k=%0d: v1=%b v2=%b, required %b 0", k, rd_valid1, rd_valid2, k == RET);
      end
      if (k >= RET) begin
        n_cmp++;
        if (rd_data1 !== rom_fn(6'd5)) begin
          n_err++; $display("FAIL single_data k=%0d: rd_data1=%0d, required %0d", k, rd_data1, rom_fn(6'd5));
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL single_idle_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_contention();
    int gs [0:31];
    logic [DW-1:0] gd [0:31];
    int n1, n2;
    logic eg1, eg2;
    n1 = 0; n2 = 0;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      if (k < 20) set_in(1'b1, AW'(n1), 1'b1, AW'(20 + n2));
      else        set_in(1'b0, 6'd0, 1'b0, 6'd0);
`ifdef FIXED_PRIO_EN
      eg1 = (k < 20);
`else
      eg1 = (k < 20) && (k % 2 == 0);
`endif
      eg2 = (k < 20) && !eg1;
      n_cmp++;
      if (gnt1 !== eg1 || gnt2 !== eg2) begin
        n_err++; $display("FAIL contend_gnt k=%0d: gnt=%b%b, required %b%b", k, gnt1, gnt2, eg1, eg2);
      end
      gs[k] = eg1 ? 1 : (eg2 ? 2 : 0);
      gd[k] = eg1 ? rom_fn(AW'(n1)) : rom_fn(AW'(20 + n2));
      if (eg1) n1++;
      if (eg2) n2++;
      if (k >= RET) begin
        n_cmp++;
        if (rd_valid1 !== (gs[k-RET] == 1) || rd_valid2 !== (gs[k-RET] == 2) ||
            (gs[k-RET] == 1 && rd_data1 !== gd[k-RET]) ||
            (gs[k-RET] == 2 && rd_data2 !== gd[k-RET])) begin
          n_err++;
          $display("FAIL contend_ret k=%0d: v=%b%b d1=%0d d2=%0d, required side %0d data %0d",
                   k, rd_valid1, rd_valid2, rd_data1, rd_data2, gs[k-RET], gd[k-RET]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int side [0:4];
    int adr  [0:4];
    side[0] = 2; adr[0] = 52;
    side[1] = 1; adr[1] = 49;
    side[2] = 1; adr[2] = 63;
    side[3] = 2; adr[3] = 50;
    side[4] = 1; adr[4] = 0;
    for (int t = 0; t < 5; t++) begin
      set_in(side[t] == 1, AW'(adr[t]), side[t] == 2, AW'(adr[t]));
      n_cmp++;
      if (gnt1 !== (side[t] == 1) || gnt2 !== (side[t] == 2)) begin
        n_err++; $display("FAIL wrap_gnt addr=%0d: gnt=%b%b, required side %0d", adr[t], gnt1, gnt2, side[t]);
      end
      for (int k = 1; k <= RET; k++) begin
        set_in(1'b0, 6'd0, 1'b0, 6'd0);
        if (k == 1) begin
          n_cmp++;
          if (rom_addr !== wrap(AW'(adr[t]))) begin
            n_err++; $display("FAIL wrap_addr in=%0d: rom_addr=%0d, required %0d", adr[t], rom_addr, wrap(AW'(adr[t])));
          end
        end
      end
      n_cmp++;
      if ((side[t] == 1 && (rd_valid1 !== 1'b1 || rd_valid2 !== 1'b0 || rd_data1 !== rom_fn(wrap(AW'(adr[t]))))) ||
          (side[t] == 2 && (rd_valid2 !== 1'b1 || rd_valid1 !== 1'b0 || rd_data2 !== rom_fn(wrap(AW'(adr[t])))))) begin
        n_err++;
        $display("FAIL wrap_data in=%0d: v=%b%b d1=%0d d2=%0d, required side %0d data %0d",
                 adr[t], rd_valid1, rd_valid2, rd_data1, rd_data2, side[t], rom_fn(wrap(AW'(adr[t]))));
      end
    end
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    set_in(1'b1, 6'd7, 1'b0, 6'd0);
    set_in(1'b0, 6'd0, 1'b0, 6'd0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rd_valid1 !== 1'b0 || rom_addr !== '0) begin
      n_err++; $display("FAIL inflight_rst: busy=%b v1=%b rom_addr=%0d, required 0 0 0", busy, rd_valid1, rom_addr);
    end
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 6'd0, 1'b0, 6'd0);
      n_cmp++;
      if (rd_valid1 !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL inflight_ghost k=%0d: v1=%b busy=%b, required 0 0", k, rd_valid1, busy);
      end
    end
    set_in(1'b1, 6'd3, 1'b1, 6'd40);
    n_cmp++;
    if (gnt1 !== 1'b1 || gnt2 !== 1'b0) begin
      n_err++; $display("FAIL inflight_ptr: gnt=%b%b, required 10", gnt1, gnt2);
    end
    set_in(1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_priority();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, AW'(k), 1'b1, AW'(k + 30));
      n_cmp++;
`ifdef FIXED_PRIO_EN
      if (gnt1 !== 1'b1 || gnt2 !== 1'b0) begin
        n_err++; $display("FAIL prio_hold k=%0d: gnt=%b%b, required 10", k, gnt1, gnt2);
      end
`else
      if (gnt1 !== (k % 2 == 0) || gnt2 !== (k % 2 == 1)) begin
        n_err++; $display("FAIL prio_hold k=%0d: gnt=%b%b, required %b%b", k, gnt1, gnt2, k % 2 == 0, k % 2 == 1);
      end
`endif
    end
    set_in(1'b0, 6'd0, 1'b1, 6'd33);
    n_cmp++;
    if (gnt1 !== 1'b0 || gnt2 !== 1'b1) begin
      n_err++; $display("FAIL prio_drop: gnt=%b%b, required 01", gnt1, gnt2);
    end
    repeat (RET + 1) set_in(1'b0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic test_random();
    localparam int N = 300;
    int gs [0:N-1];
    logic [DW-1:0] gd [0:N-1];
    logic [AW-1:0] gw [0:N-1];
    logic p1, p2, eb;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] last1, last2;
    int prefer2, g;
    p1 = 0; p2 = 0; a1 = '0; a2 = '0;
    last1 = '0; last2 = '0; prefer2 = 0;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      if (!p1) begin p1 = ($urandom_range(0, 2) != 0); a1 = AW'($urandom_range(0, 63)); end
      if (!p2) begin p2 = ($urandom_range(0, 2) != 0); a2 = AW'($urandom_range(0, 63)); end
      set_in(p1, a1, p2, a2);
      if (p1 && p2) begin
`ifdef FIXED_PRIO_EN
        g = 1;
`else
        g = prefer2 ? 2 : 1;
`endif
      end else begin
        g = p1 ? 1 : (p2 ? 2 : 0);
      end
      if (g != 0) prefer2 = (g == 1);
      gs[k] = g;
      gw[k] = wrap(g == 2 ? a2 : a1);
      gd[k] = rom_fn(gw[k]);
      n_cmp++;
      if (gnt1 !== (g == 1) || gnt2 !== (g == 2)) begin
        n_err++; $display("FAIL rand_gnt k=%0d: gnt=%b%b, required side %0d", k, gnt1, gnt2, g);
      end
      if (k >= 1 && gs[k-1] != 0) begin
        n_cmp++;
        if (rom_addr !== gw[k-1]) begin
          n_err++; $display("FAIL rand_addr k=%0d: rom_addr=%0d, required %0d", k, rom_addr, gw[k-1]);
        end
      end
      eb = 1'b0;
      for (int j = 1; j <= ROM_LAT + 1; j++) if (k - j >= 0 && gs[k-j] != 0) eb = 1'b1;
      if (k >= RET && gs[k-RET] == 1) last1 = gd[k-RET];
      if (k >= RET && gs[k-RET] == 2) last2 = gd[k-RET];
      n_cmp++;
      if (rd_valid1 !== (k >= RET && gs[k-RET] == 1) || rd_valid2 !== (k >= RET && gs[k-RET] == 2) ||
          rd_data1 !== last1 || rd_data2 !== last2 || busy !== eb) begin
        n_err++;
        $display("FAIL rand_ret k=%0d: v=%b%b d1=%0d d2=%0d busy=%b, required side %0d d1=%0d d2=%0d busy=%b",
                 k, rd_valid1, rd_valid2, rd_data1, rd_data2, busy,
                 (k >= RET) ? gs[k-RET] : 0, last1, last2, eb);
      end
      if (g == 1) p1 = 1'b0;
      if (g == 2) p2 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_reset_inflight();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, required finish before 500000");
    $fatal(1);
  end

endmodule
